// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle sequencer for MULT/MULTU/DIV/DIVU.
// Owns HI/LO and runs an iterative shift-add multiplier or a restoring divider.
// While an op is in flight, busy stays high so the single-cycle datapath stalls.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request a new op (sampled only in IDLE)
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a  - multiplicand / dividend (rs)
//   src_b  - multiplier / divisor (rt)
//   abort  - pipeline flush; cancels the in-flight op
//   mthi   - write wdata to HI (IDLE only)
//   mtlo   - write wdata to LO (IDLE only)
//   wdata  - data for mthi/mtlo
//   busy   - op in flight (stall request)
//   done   - one-cycle pulse when an op updates HI/LO
//   dz     - sticky divide-by-zero flag; cleared by the next accepted start
//   hi, lo - HI and LO registers
//
// Optional build macro MULDIV_EARLY_OUT_EN: when it is defined, a multiply
// leaves CALC as soon as the remaining multiplier bits are all zero.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic               r_sign_a;   // sign of a signed-op operand, 0 for unsigned ops
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_src_a;    // raw dividend, needed for the divide-by-zero result
  logic [WIDTH-1:0]   r_a;        // divide: dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   r_b;        // multiply: multiplier shifting right; divide: divisor
  logic [2*WIDTH-1:0] r_acc;      // multiply: product; divide: remainder in low half
  logic [2*WIDTH-1:0] r_mcand;    // multiplicand, shifted left once per iteration
  logic               r_busy;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand conditioning at start: signed ops work on magnitudes.
  logic             w_in_signed;
  logic             w_in_neg_a;
  logic             w_in_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_in_signed = ~op[0];
  assign w_in_neg_a  = w_in_signed & src_a[WIDTH-1];
  assign w_in_neg_b  = w_in_signed & src_b[WIDTH-1];
  assign w_mag_a     = w_in_neg_a ? -src_a : src_a;
  assign w_mag_b     = w_in_neg_b ? -src_b : src_b;

  logic w_is_div;
  logic w_div_zero;
  logic w_last_iter;
  logic w_calc_done;

  assign w_is_div    = r_op[1];
  assign w_div_zero  = w_is_div & (r_b == '0);
  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  // After this iteration only r_b[WIDTH-1:1] remain; if they are all zero,
  // later iterations would add nothing.
  assign w_calc_done = w_last_iter | (~w_is_div & (r_b[WIDTH-1:1] == '0));
`else
  assign w_calc_done = w_last_iter;
`endif

  // Restoring divide step: shift in the next dividend bit, try a subtract.
  // The remainder is always below the divisor, so the trial fits in WIDTH+1 bits.
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_step;

  assign w_trial    = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_diff     = w_trial - {1'b0, r_b};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_rem_step = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

  // Shift-add multiply step.
  logic [2*WIDTH-1:0] w_prod_step;
  assign w_prod_step = r_b[0] ? (r_acc + r_mcand) : r_acc;

  // Sign fix-up. The remainder follows the dividend; the quotient and the
  // product are negated when the operand signs differ.
  logic               w_neg_res;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_neg_res  = r_sign_a ^ r_sign_b;
  assign w_rem_mag  = r_acc[WIDTH-1:0];
  assign w_quo_fix  = w_neg_res ? -r_a : r_a;
  assign w_rem_fix  = r_sign_a ? -w_rem_mag : w_rem_mag;
  assign w_prod_fix = w_neg_res ? -r_acc : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= 2'b00;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_src_a  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // A move in the same cycle as start is dropped.
            r_op     <= op;
            r_sign_a <= w_in_neg_a;
            r_sign_b <= w_in_neg_b;
            r_src_a  <= src_a;
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_cnt    <= '0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_CALC: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_div_zero) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_is_div) begin
              r_a   <= {r_a[WIDTH-2:0], w_fits};
              r_acc <= {{WIDTH{1'b0}}, w_rem_step};
            end else begin
              r_acc   <= w_prod_step;
              r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
              r_b     <= {1'b0, r_b[WIDTH-1:1]};
            end
            if (w_calc_done) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_div_zero) begin
              r_lo <= '1;
              r_hi <= r_src_a;
              r_dz <= 1'b1;
            end else if (w_is_div) begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end else begin
              r_lo <= w_prod_fix[WIDTH-1:0];
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
